// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller.
// State enum, register address type and default latency.
package hazard_ctrl_pkg;

  localparam int MUL_LAT_DEF = 4;
  localparam int REG_A_W_DEF = 5;

  typedef logic [REG_A_W_DEF-1:0] RegAddr;

  typedef enum logic {
    RUN,
    MUL_BUSY
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_mul_timer.sv
// Down-counter tracking the remaining stall cycles
// of a multi-cycle X-stage op.
module mul_timer #(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CW = $clog2(MUL_LAT);
  localparam logic [CW-1:0] LOAD_V = CW'(MUL_LAT - 2);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_V;
    end else if (dec_i) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the F/D, D/X, X/M registers.
// Optional perf counters under `HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int REG_A_W = REG_A_W_DEF,
  parameter int PERF_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_A_W-1:0] d_rs_a,
  input  logic [REG_A_W-1:0] d_rt_a,
  input  logic               d_uses_rs,
  input  logic               d_uses_rt,
  input  logic [REG_A_W-1:0] x_rd_a,
  input  logic               x_mem_read,
  input  logic               x_branch_taken,
  input  logic               x_multi,
  output logic               stall_f,
  output logic               stall_d,
  output logic               stall_dx,
  output logic               bubble_dx,
  output logic               flush_fd,
  output logic               bubble_xm,
  output logic               pc_sel_jmp,
  output logic               busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_stall_cnt,
  output logic [PERF_W-1:0]  perf_flush_cnt
`endif
);

  hazard_state_t state_q, state_d;
  logic load_use;
  logic cnt_zero;
  logic tmr_load;
  logic tmr_dec;

  assign load_use = x_mem_read
                 && (x_rd_a != '0)
                 && ((d_uses_rs && (d_rs_a == x_rd_a))
                  || (d_uses_rt && (d_rt_a == x_rd_a)));

  mul_timer #(
    .MUL_LAT(MUL_LAT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_dx   = 1'b0;
    bubble_dx  = 1'b0;
    flush_fd   = 1'b0;
    bubble_xm  = 1'b0;
    pc_sel_jmp = 1'b0;
    busy       = 1'b0;
    // Everything is held quiet while reset is asserted.
    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (x_branch_taken) begin
            pc_sel_jmp = 1'b1;
            flush_fd   = 1'b1;
            bubble_dx  = 1'b1;
          end else if (x_multi) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_dx  = 1'b1;
            bubble_xm = 1'b1;
            tmr_load  = 1'b1;
            state_d   = MUL_BUSY;
          end else if (load_use) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            bubble_dx = 1'b1;
          end
        end
        MUL_BUSY: begin
          busy = 1'b1;
          if (!cnt_zero) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_dx  = 1'b1;
            bubble_xm = 1'b1;
            tmr_dec   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_d) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if (flush_fd) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MUL_LAT 4 and 2)
// against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int W = 5;
  localparam int LAT_A = 4;
  localparam int LAT_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] d_rs_a = '0;
  logic [W-1:0] d_rt_a = '0;
  logic d_uses_rs = 1'b0;
  logic d_uses_rt = 1'b0;
  logic [W-1:0] x_rd_a = '0;
  logic x_mem_read = 1'b0;
  logic x_branch_taken = 1'b0;
  logic x_multi = 1'b0;

  // {stall_f,stall_d,stall_dx,bubble_dx,
  //  flush_fd,bubble_xm,pc_sel_jmp,busy}
  wire [7:0] ya;
  wire [7:0] yb;
`ifdef HAZARD_PERF_EN
  wire [31:0] pa_st, pa_fl, pb_st, pb_fl;
`endif

  int checks = 0;
  int passes = 0;
  int left_a = 0;
  int left_b = 0;
  int pst_a = 0, pfl_a = 0;
  int pst_b = 0, pfl_b = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(LAT_A), .REG_A_W(W)) u_a (
    .clk(clk), .rst(rst),
    .d_rs_a(d_rs_a), .d_rt_a(d_rt_a),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .x_rd_a(x_rd_a), .x_mem_read(x_mem_read),
    .x_branch_taken(x_branch_taken),
    .x_multi(x_multi),
    .stall_f(ya[7]), .stall_d(ya[6]),
    .stall_dx(ya[5]), .bubble_dx(ya[4]),
    .flush_fd(ya[3]), .bubble_xm(ya[2]),
    .pc_sel_jmp(ya[1]), .busy(ya[0])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(pa_st)
    , .perf_flush_cnt(pa_fl)
`endif
  );

  hazard_ctrl #(.MUL_LAT(LAT_B), .REG_A_W(W)) u_b (
    .clk(clk), .rst(rst),
    .d_rs_a(d_rs_a), .d_rt_a(d_rt_a),
    .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .x_rd_a(x_rd_a), .x_mem_read(x_mem_read),
    .x_branch_taken(x_branch_taken),
    .x_multi(x_multi),
    .stall_f(yb[7]), .stall_d(yb[6]),
    .stall_dx(yb[5]), .bubble_dx(yb[4]),
    .flush_fd(yb[3]), .bubble_xm(yb[2]),
    .pc_sel_jmp(yb[1]), .busy(yb[0])
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(pb_st)
    , .perf_flush_cnt(pb_fl)
`endif
  );

  // left = busy cycles still to come after the
  // issuing cycle; the last of them releases.
  function automatic logic [7:0] model(int left);
    logic lu;
    lu = x_mem_read && (x_rd_a != 0)
      && ((d_uses_rs && d_rs_a == x_rd_a)
       || (d_uses_rt && d_rt_a == x_rd_a));
    if (!rst) return 8'h00;
    if (left > 1) return 8'b1110_0101;
    if (left == 1) return 8'b0000_0001;
    if (x_branch_taken) return 8'b0001_1010;
    if (x_multi) return 8'b1110_0100;
    if (lu) return 8'b1101_0000;
    return 8'h00;
  endfunction

  function automatic int nxt(int left, int lat);
    if (!rst) return 0;
    if (left > 0) return left - 1;
    if (x_multi && !x_branch_taken) return lat - 1;
    return 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  task automatic drv(logic br, logic mu, logic mr,
                     int rd, int rs, int rt,
                     logic us, logic ut);
    x_branch_taken = br;
    x_multi = mu;
    x_mem_read = mr;
    x_rd_a = W'(rd);
    d_rs_a = W'(rs);
    d_rt_a = W'(rt);
    d_uses_rs = us;
    d_uses_rt = ut;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc(string tag);
    logic [7:0] ea, eb;
    @(negedge clk);
    ea = model(left_a);
    eb = model(left_b);
    chk({tag, "_a"}, 32'(ya), 32'(ea));
    chk({tag, "_b"}, 32'(yb), 32'(eb));
`ifdef HAZARD_PERF_EN
    chk({tag, "_pst_a"}, pa_st, pst_a);
    chk({tag, "_pfl_a"}, pa_fl, pfl_a);
    chk({tag, "_pst_b"}, pb_st, pst_b);
    chk({tag, "_pfl_b"}, pb_fl, pfl_b);
`endif
    @(posedge clk);
    if (!rst) begin
      pst_a = 0; pfl_a = 0;
      pst_b = 0; pfl_b = 0;
    end else begin
      pst_a += int'(ea[6]); pfl_a += int'(ea[3]);
      pst_b += int'(eb[6]); pfl_b += int'(eb[3]);
    end
    left_a = nxt(left_a, LAT_A);
    left_b = nxt(left_b, LAT_B);
    #1;
  endtask

  initial begin
    idle();
    cyc("rst_hold");
    cyc("rst_hold2");
    rst = 1'b1;
    cyc("idle0");

    drv(0, 0, 1, 5, 5, 0, 1, 0);
    cyc("lu_r5");
    idle();
    cyc("lu_after");
    drv(0, 0, 1, 0, 0, 0, 1, 1);
    cyc("lu_r0");

    drv(1, 0, 1, 5, 5, 5, 1, 1);
    cyc("br_lu");
    idle();
    cyc("br_after");

    drv(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("mul");
    idle();
    cyc("mul_after");
`ifdef HAZARD_PERF_EN
    chk("perf_stall_4", pa_st, 32'd4);
    chk("perf_flush_1", pa_fl, 32'd1);
`endif

    drv(0, 1, 1, 3, 3, 3, 1, 1);
    for (int i = 0; i < 8; i++) cyc("b2b");
    idle();
    cyc("b2b_after");

    drv(0, 1, 0, 0, 0, 0, 0, 0);
    cyc("rmul0");
    cyc("rmul1");
    rst = 1'b0;
    #1;
    chk("rst_async_a", 32'(ya), 32'd0);
    chk("rst_async_b", 32'(yb), 32'd0);
    cyc("rst_mid");
    rst = 1'b1;
    idle();
    cyc("post_rst");
    cyc("post_rst2");

    for (int i = 0; i < 2000; i++) begin
      drv($urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) rst = 1'b0;
      else rst = 1'b1;
      cyc("rnd");
    end
    rst = 1'b1;
    idle();
    cyc("final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
